// File: rtl/sdram_sched_if.sv
// Scheduler-facing bundle: the client read/write port plus the four sub-engine req/fin pairs,
// the latched address/data going to the engines and the DRAM pin-mux select.
interface sdram_sched_if;
  // Handshakes: a client holds irdreq/iwrreq (address/data stable) until its one-cycle
  // ordack/owrack; the scheduler holds an engine o*_req level until it samples that engine's
  // one-cycle i*_fin, and drops the req on the following cycle.
  logic        irdreq;
  logic        iwrreq;
  logic [12:0] irow;
  logic [9:0]  icolumn;
  logic [1:0]  ibank;
  logic [15:0] iwdata;
  logic        ordack;
  logic [15:0] ordata;
  logic        owrack;
  logic        oready;
  logic        oerr;
  logic        oinit_req;
  logic        oref_req;
  logic        ord_req;
  logic        owr_req;
  logic        iinit_fin;
  logic        iref_fin;
  logic        ird_fin;
  logic        iwr_fin;
  logic [15:0] ieng_data;
  logic [12:0] orow;
  logic [9:0]  ocolumn;
  logic [1:0]  obank;
  logic [15:0] owdata;
  logic [1:0]  osel;
  logic [2:0]  dbg_state;

  modport slave (
    input  irdreq, iwrreq, irow, icolumn, ibank, iwdata,
    input  iinit_fin, iref_fin, ird_fin, iwr_fin, ieng_data,
    output ordack, ordata, owrack, oready, oerr,
    output oinit_req, oref_req, ord_req, owr_req,
    output orow, ocolumn, obank, owdata, osel, dbg_state
  );

  modport master (
    output irdreq, iwrreq, irow, icolumn, ibank, iwdata,
    output iinit_fin, iref_fin, ird_fin, iwr_fin, ieng_data,
    input  ordack, ordata, owrack, oready, oerr,
    input  oinit_req, oref_req, ord_req, owr_req,
    input  orow, ocolumn, obank, owdata, osel, dbg_state
  );
endinterface

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: sequences init/refresh/read/write engines, arbitrates the client
// read and write ports round-robin, and gives periodic refresh priority over client traffic.
module sdram_sched #(
  parameter int REF_INTERVAL = 780,
  parameter int TIMEOUT      = 1023
) (
  input logic          iclk,
  input logic          ireset,
  sdram_sched_if.slave bus
);
  localparam int RW = $clog2(REF_INTERVAL);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] REF_RELOAD = RW'(REF_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_INIT_START = 3'd0,
    S_INIT       = 3'd1,
    S_IDLE       = 3'd2,
    S_REF        = 3'd3,
    S_RD         = 3'd4,
    S_WR         = 3'd5,
    S_ACK        = 3'd6
  } state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;
  logic          last_wr;
  logic [TW-1:0] to_cnt;

  logic ref_take, ref_tick, eng_busy, eng_fin, timed_out;

  assign ref_take  = (state == S_IDLE) && ref_pend;
  assign ref_tick  = bus.oready && (ref_cnt == '0);
  assign eng_busy  = state inside {S_INIT, S_REF, S_RD, S_WR};
  assign eng_fin   = ((state == S_INIT) && bus.iinit_fin) || ((state == S_REF) && bus.iref_fin) ||
                     ((state == S_RD) && bus.ird_fin)     || ((state == S_WR) && bus.iwr_fin);
  assign timed_out = eng_busy && (to_cnt == TW'(TIMEOUT - 1)) && !eng_fin;
  assign bus.dbg_state = state;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state         <= S_INIT_START;
      ref_cnt       <= REF_RELOAD;
      ref_pend      <= 1'b0;
      last_wr       <= 1'b1;
      to_cnt        <= '0;
      bus.ordack    <= 1'b0;
      bus.owrack    <= 1'b0;
      bus.oready    <= 1'b0;
      bus.oerr      <= 1'b0;
      bus.oinit_req <= 1'b0;
      bus.oref_req  <= 1'b0;
      bus.ord_req   <= 1'b0;
      bus.owr_req   <= 1'b0;
      bus.osel      <= 2'd0;
      bus.orow      <= '0;
      bus.ocolumn   <= '0;
      bus.obank     <= '0;
      bus.owdata    <= '0;
      bus.ordata    <= '0;
    end else begin
      bus.ordack <= 1'b0;
      bus.owrack <= 1'b0;
      to_cnt     <= to_cnt + 1'b1;

      // A tick while the previous refresh is still unserved is a missed refresh.
      if (bus.oready) ref_cnt <= ref_tick ? REF_RELOAD : ref_cnt - 1'b1;
      if (ref_tick && ref_pend && !ref_take) bus.oerr <= 1'b1;
      ref_pend <= (ref_pend && !ref_take) || ref_tick;

      case (state)
        S_INIT_START: begin
          state         <= S_INIT;
          bus.oinit_req <= 1'b1;
          bus.osel      <= 2'd0;
          to_cnt        <= '0;
        end
        S_INIT: if (bus.iinit_fin) begin
          bus.oinit_req <= 1'b0;
          bus.oready    <= 1'b1;
          state         <= S_IDLE;
        end
        S_IDLE: begin
          to_cnt <= '0;
          if (ref_pend) begin
            state        <= S_REF;
            bus.oref_req <= 1'b1;
            bus.osel     <= 2'd1;
          end else if (bus.irdreq && (!bus.iwrreq || last_wr)) begin
            bus.orow    <= bus.irow;
            bus.ocolumn <= bus.icolumn;
            bus.obank   <= bus.ibank;
            last_wr     <= 1'b0;
            state       <= S_RD;
            bus.ord_req <= 1'b1;
            bus.osel    <= 2'd2;
          end else if (bus.iwrreq) begin
            bus.orow    <= bus.irow;
            bus.ocolumn <= bus.icolumn;
            bus.obank   <= bus.ibank;
            bus.owdata  <= bus.iwdata;
            last_wr     <= 1'b1;
            state       <= S_WR;
            bus.owr_req <= 1'b1;
            bus.osel    <= 2'd3;
          end
        end
        S_REF: if (bus.iref_fin) begin
          bus.oref_req <= 1'b0;
          state        <= S_IDLE;
        end
        S_RD: if (bus.ird_fin) begin
          bus.ord_req <= 1'b0;
          bus.ordata  <= bus.ieng_data;
          bus.ordack  <= 1'b1;
          state       <= S_ACK;
        end
        S_WR: if (bus.iwr_fin) begin
          bus.owr_req <= 1'b0;
          bus.owrack  <= 1'b1;
          state       <= S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_INIT_START;
      endcase

      // A stuck engine forces a full re-init; the aborted access is never acknowledged.
      if (timed_out) begin
        bus.oerr      <= 1'b1;
        bus.oready    <= 1'b0;
        bus.oinit_req <= 1'b0;
        bus.oref_req  <= 1'b0;
        bus.ord_req   <= 1'b0;
        bus.owr_req   <= 1'b0;
        ref_pend      <= 1'b0;
        ref_cnt       <= REF_RELOAD;
        state         <= S_INIT_START;
      end
    end
  end
endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: three instances (default, short refresh interval, short
// timeout) share one clock and an auto-responding engine model.
module tb_sdram_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       rdreq, wrreq;
  logic [2:0][12:0] row;
  logic [2:0][9:0]  col;
  logic [2:0][1:0]  bank;
  logic [2:0][15:0] wdata, eng_data;
  logic [2:0][3:0]  fin, man_fin, fin_en;  // bit 0 init, 1 ref, 2 rd, 3 wr
  logic [2:0][3:0]  req;
  logic [2:0]       rdack, wrack, ready, err;
  logic [2:0][15:0] rdata, owd;
  logic [2:0][12:0] orow;
  logic [2:0][9:0]  ocol;
  logic [2:0][1:0]  obank, sel;
  logic [2:0][2:0]  dbg;

  int dly [3][4];
  int n_err = 0;
  int n_chk = 0;
  int rdack_cnt [3] = '{0, 0, 0};
  int wrack_cnt [3] = '{0, 0, 0};
  logic [16:0] exp_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdram_sched_if bus_if ();
    sdram_sched #(
      .REF_INTERVAL(g == 1 ? 20 : 780),
      .TIMEOUT     (g == 2 ? 16 : 1023)
    ) u_dut (
      .iclk  (clk),
      .ireset(rst[g]),
      .bus   (bus_if.slave)
    );
    assign bus_if.irdreq    = rdreq[g];
    assign bus_if.iwrreq    = wrreq[g];
    assign bus_if.irow      = row[g];
    assign bus_if.icolumn   = col[g];
    assign bus_if.ibank     = bank[g];
    assign bus_if.iwdata    = wdata[g];
    assign bus_if.ieng_data = eng_data[g];
    assign bus_if.iinit_fin = fin[g][0] | man_fin[g][0];
    assign bus_if.iref_fin  = fin[g][1] | man_fin[g][1];
    assign bus_if.ird_fin   = fin[g][2] | man_fin[g][2];
    assign bus_if.iwr_fin   = fin[g][3] | man_fin[g][3];
    assign req[g]   = {bus_if.owr_req, bus_if.ord_req, bus_if.oref_req, bus_if.oinit_req};
    assign rdack[g] = bus_if.ordack;
    assign wrack[g] = bus_if.owrack;
    assign ready[g] = bus_if.oready;
    assign err[g]   = bus_if.oerr;
    assign rdata[g] = bus_if.ordata;
    assign owd[g]   = bus_if.owdata;
    assign orow[g]  = bus_if.orow;
    assign ocol[g]  = bus_if.ocolumn;
    assign obank[g] = bus_if.obank;
    assign sel[g]   = bus_if.osel;
    assign dbg[g]   = bus_if.dbg_state;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdack[i]) rdack_cnt[i] <= rdack_cnt[i] + 1;
      if (wrack[i]) wrack_cnt[i] <= wrack_cnt[i] + 1;
    end
  end

  // Engine model: pulses fin in the dly-th cycle that the matching req has been high.
  initial begin : engine_model
    int cnt [3][4];
    fin = '0;
    for (int i = 0; i < 3; i++) for (int e = 0; e < 4; e++) cnt[i][e] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        for (int e = 0; e < 4; e++) begin
          cnt[i][e] = req[i][e] ? cnt[i][e] + 1 : 0;
          fin[i][e] = fin_en[i][e] && req[i][e] && (cnt[i][e] == dly[i][e]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input int i, input int e, input string tag);
    int n;
    n = 0;
    while (!req[i][e] && n < 100) begin @(negedge clk); n++; end
    check(tag, req[i][e], 1);
  endtask

  task automatic do_reset(input int i);
    int n;
    @(negedge clk);
    rst[i] = 1'b1;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
    n = 0;
    while (!ready[i] && n < 200) begin @(negedge clk); n++; end
    check("ready_up", ready[i], 1);
  endtask

  initial begin : main
    int n, t, t_ref, grants, acks, rd_after, base;
    logic prev_rd, ref_seen;
    logic [16:0] got;

    rst = '1; rdreq = '0; wrreq = '0; row = '0; col = '0; bank = '0;
    wdata = '0; eng_data = '0; man_fin = '0; fin_en = '1;
    fin_en[1][1] = 1'b0;  // refresh never finishes on the short-interval instance
    fin_en[2][2] = 1'b0;  // reads never finish on the short-timeout instance
    for (int i = 0; i < 3; i++) begin
      dly[i][0] = 10; dly[i][1] = 2; dly[i][2] = 4; dly[i][3] = 3;
    end
    dly[1][2] = 3;

    // Reset state and init sequence
    repeat (2) @(negedge clk);
    check("rst_ctl", {req[0], rdack[0], wrack[0], ready[0], err[0], sel[0]}, 0);
    check("rst_addr", {orow[0], ocol[0], obank[0]}, 0);
    check("rst_data", {owd[0], rdata[0]}, 0);
    check("rst_state", dbg[0], 0);
    rst = '0;
    wait_req(0, 0, "init_req_up");
    check("init_sel", sel[0], 0);
    n = 0;
    while (req[0][0] && n < 100) begin @(negedge clk); n++; end
    check("init_req_len", n, 10);
    check("init_ready", ready[0], 1);
    check("init_others", {req[0], rdack[0], wrack[0], err[0], sel[0]}, 0);

    // Single read
    row[0] = 13'd5; col[0] = 10'd3; bank[0] = 2'd1; eng_data[0] = 16'h001D;
    base = rdack_cnt[0];
    rdreq[0] = 1'b1;
    wait_req(0, 2, "rd_req_up");
    check("rd_row", orow[0], 5);
    check("rd_col", ocol[0], 3);
    check("rd_bank", obank[0], 1);
    check("rd_sel", sel[0], 2);
    row[0] = 13'h1ABC;
    n = 0;
    while (!rdack[0] && n < 100) begin @(negedge clk); n++; end
    check("rd_latency", n, 4);
    check("rd_data", rdata[0], 16'h001D);
    rdreq[0] = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", rdack[0], 0);
    repeat (3) @(negedge clk);
    check("rd_ack_count", rdack_cnt[0] - base, 1);
    check("rd_row_held", orow[0], 5);

    // Both ports requesting: reads and writes alternate, read first after reset
    do_reset(0);
    row[0] = 13'd7; wdata[0] = 16'hA000; eng_data[0] = 16'h0100;
    exp_q.delete();
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b1, 16'hA000});
    exp_q.push_back({1'b0, 16'h0101});
    exp_q.push_back({1'b1, 16'hA001});
    rdreq[0] = 1'b1; wrreq[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(rdack[0] || wrack[0]) && n < 100) begin @(negedge clk); n++; end
      check("alt_ack_seen", rdack[0] | wrack[0], 1);
      got = wrack[0] ? {1'b1, owd[0]} : {1'b0, rdata[0]};
      check("alt_grant", got, exp_q.pop_front());
      if (wrack[0]) wdata[0] = wdata[0] + 16'd1;
      else eng_data[0] = eng_data[0] + 16'd1;
      if (k == 3) begin rdreq[0] = 1'b0; wrreq[0] = 1'b0; end
      @(negedge clk);
    end

    // Reset in the middle of a write
    fin_en[0][3] = 1'b0;
    wdata[0] = 16'h5A5A;
    wrreq[0] = 1'b1;
    wait_req(0, 3, "wr_req_up");
    check("wr_sel", sel[0], 3);
    check("wr_data_latched", owd[0], 16'h5A5A);
    repeat (3) @(negedge clk);
    base = wrack_cnt[0];
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_reqs", req[0], 0);
    check("mid_rst_sel", sel[0], 0);
    check("mid_rst_ready", ready[0], 0);
    wrreq[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    man_fin[0][3] = 1'b1;
    @(negedge clk);
    man_fin[0][3] = 1'b0;
    repeat (20) @(negedge clk);
    check("late_fin_no_ack", wrack_cnt[0] - base, 0);
    check("reinit_ready", ready[0], 1);
    fin_en[0][3] = 1'b1;

    // Refresh priority and missed refresh (interval 20, refresh never completes)
    rdreq[1] = 1'b1;
    do_reset(1);
    base = rdack_cnt[1];
    t = 0; t_ref = 0; grants = 0; acks = 0; rd_after = 0;
    prev_rd = 1'b0; ref_seen = 1'b0;
    while (!err[1] && t < 150) begin
      @(negedge clk);
      t++;
      if (req[1][2] && !prev_rd) grants++;
      prev_rd = req[1][2];
      if (req[1][1] && !ref_seen) begin
        ref_seen = 1'b1;
        t_ref = t;
        acks = rdack_cnt[1] - base;
        check("ref_sel", sel[1], 1);
        check("ref_no_rd", req[1][2], 0);
      end
      if (ref_seen && req[1][2]) rd_after++;
    end
    check("ref_start", t_ref, 21);
    check("ref_rd_grants", grants, 4);
    check("ref_rd_acks", acks, 4);
    check("ref_blocks_rd", rd_after, 0);
    check("miss_ref_time", t, 60);
    check("miss_ref_err", err[1], 1);
    check("ref_still_req", req[1][1], 1);
    rdreq[1] = 1'b0;

    // Engine timeout (TIMEOUT 16, read never finishes)
    do_reset(2);
    base = rdack_cnt[2];
    rdreq[2] = 1'b1;
    wait_req(2, 2, "to_req_up");
    check("to_sel", sel[2], 2);
    n = 0;
    while (req[2][2] && n < 100) begin @(negedge clk); n++; end
    check("to_len", n, 16);
    check("to_err", err[2], 1);
    check("to_ready", ready[2], 0);
    rdreq[2] = 1'b0;
    @(negedge clk);
    check("to_reinit", req[2][0], 1);
    repeat (15) @(negedge clk);
    check("to_no_ack", rdack_cnt[2] - base, 0);
    check("to_err_sticky", err[2], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/sdram_sched.md
Name: sdram_sched

Overview:
- Top-level command scheduler for the SDRAM datapath.
- Sequences the init, auto-refresh, read and write sub-engines through their req/fin handshakes.
- Arbitrates one client read port and one client write port onto the single SDRAM, with periodic refresh taking priority.
- Drives the select for the DRAM pin mux that sits between the sub-engines and the DRAM_* pins.

Parameters:
REF_INTERVAL, 780, iclk cycles between refresh requests (counter reload value).
TIMEOUT, 1023, max iclk cycles to wait for any engine fin before error.

Ports:
iclk  in  1  system clock; all logic on rising edge.
ireset  in  1  synchronous, active-high reset.
irdreq  in  1  client read request; held with address until ordack.
iwrreq  in  1  client write request; held with address/data until owrack.
irow  in  13  client row address.
icolumn  in  10  client column address.
ibank  in  2  client bank address.
iwdata  in  16  client write data.
ordack  out  1  one-cycle read-complete pulse; ordata valid this cycle.
ordata  out  16  read data, registered.
owrack  out  1  one-cycle write-complete pulse.
oready  out  1  high once init engine has finished.
oerr  out  1  sticky: engine timeout or missed refresh.
oinit_req / oref_req / ord_req / owr_req  out  1 each  engine start requests.
iinit_fin / iref_fin / ird_fin / iwr_fin  in  1 each  engine done pulses.
ieng_data  in  16  read engine data (odata of sdram_read), valid with ird_fin.
orow  out  13  latched row to engines.
ocolumn  out  10  latched column to engines.
obank  out  2  latched bank to engines.
owdata  out  16  latched write data to engines.
osel  out  2  DRAM pin mux select: 0 init, 1 refresh, 2 read, 3 write.

Behaviour:
- Reset (sync, ireset=1 at edge): state S_INIT_START.
  - All outputs 0: req lines, acks, oready, oerr, osel, orow/ocolumn/obank/owdata/ordata.
  - Refresh counter loads REF_INTERVAL-1; ref_pend=0; last_grant=write.
  - Mid-operation reset aborts immediately: engine reqs drop on the next cycle and no ack is issued.
- States: S_INIT_START, S_INIT, S_IDLE, S_REF, S_RD, S_WR, S_ACK.
- S_INIT_START -> S_INIT after 1 cycle.
- S_INIT:
  - osel=0, oinit_req=1.
  - On iinit_fin: oready=1 from the next cycle, go to S_IDLE.
- Req lines are level: asserted for the whole engine state and deasserted on the cycle after fin is sampled.
- A fin seen while not in the matching state is ignored.
- Refresh counter:
  - Runs only while oready=1; decrements each cycle.
  - At 0: reloads REF_INTERVAL-1 and sets ref_pend.
  - If ref_pend is already 1 at that point, set oerr (missed refresh).
- S_IDLE priority, evaluated each cycle:
  - ref_pend -> S_REF (clears ref_pend).
  - Else irdreq and iwrreq both high -> grant the port not equal to last_grant.
  - Else grant whichever single request is high.
  - Grant latches irow/icolumn/ibank (and iwdata for write) into the o* address/data regs, updates last_grant, and goes to S_RD or S_WR.
- S_REF: osel=1, oref_req=1; iref_fin -> S_IDLE, no client ack.
- S_RD: osel=2, ord_req=1; ird_fin -> capture ieng_data into ordata, go to S_ACK.
- S_WR: osel=3, owr_req=1; iwr_fin -> go to S_ACK.
- S_ACK:
  - One cycle; pulse ordack or owrack per the grant.
  - Return to S_IDLE.
  - The client drops its req on the cycle after the ack, so the earliest regrant is 2 cycles after the ack.
- A refresh that becomes pending during S_RD/S_WR waits; the current access completes first.
- Timeout: a per-state cycle counter is cleared on state entry.
  - Reaching TIMEOUT in S_INIT/S_REF/S_RD/S_WR sets oerr, drops all reqs, clears oready and goes to S_INIT_START (full re-init).
  - No ack is issued for the aborted access.
- Latency: with fin arriving k cycles after req rises, the read ack occurs k+2 cycles after the grant cycle.
- osel holds its last value in S_IDLE/S_ACK.
- Address/data regs change only on grant.

Test Plan:
- Reset 2 cycles, iinit_fin pulsed 10 cycles after oinit_req -> oinit_req high for 10 cycles, osel=0, oready=1 one cycle later, all other outputs 0.
- irdreq with row=5, col=3, bank=1; ird_fin after 4 cycles with ieng_data=16'h001D -> orow=5, ocolumn=3, obank=1, osel=2; ordack single pulse with ordata=29.
- irdreq and iwrreq both high continuously -> grants alternate R, W, R, W; first grant is read; owrack carries owdata=iwdata latched at grant.
- REF_INTERVAL=20 with irdreq held -> in-progress read completes, then oref_req/osel=1 before the next read grant; with iref_fin withheld past 2 intervals -> oerr=1.
- TIMEOUT=16, ird_fin never asserted -> at 16 cycles oerr=1, ord_req=0, oready=0, oinit_req=1 after re-entering init; no ordack.
- ireset asserted mid-S_WR -> next cycle owr_req=0, osel=0, oready=0; a late iwr_fin after reset produces no owrack.
